// File: rtl/s4ga2.sv
// s4ga2 - serially configured LUT fabric with a flow-controlled segment stream.
//
// Sweeps N K-input LUTs in order. Each LUT receives a configuration frame of
// K input indices (IDX_SEGS segments each) followed by a 2^K-bit mask
// (MASK_SEGS segments), MSB-first, then evaluates on the last mask segment.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   si        - configuration segment
//   si_valid  - segment is consumed this cycle; low stalls the block
//   si_sof    - qualified by si_valid, marks segment 0 of LUT 0
//   inputs    - fabric inputs, LUTs 0..I-1 pass these through
//   outputs   - registered lut_q[N-O+j], captured at sweep end
//   out_valid - one-cycle pulse when outputs update
//   sync_err  - sticky flag, set by an si_sof at any position but the start
module s4ga2 #(
    parameter int N    = 71,
    parameter int K    = 5,
    parameter int I    = 2,
    parameter int O    = 8,
    parameter int SI_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SI_W-1:0] si,
    input  logic            si_valid,
    input  logic            si_sof,
    input  logic [I-1:0]    inputs,
    output logic [O-1:0]    outputs,
    output logic            out_valid,
    output logic            sync_err
);
    localparam int N_W       = $clog2(N);
    localparam int IDX_SEGS  = (N_W + SI_W - 1) / SI_W;
    localparam int MASK_BITS = 1 << K;
    localparam int MASK_SEGS = (MASK_BITS + SI_W - 1) / SI_W;
    localparam int MAX_SEGS  = (MASK_SEGS > IDX_SEGS) ? MASK_SEGS : IDX_SEGS;
    localparam int SR_W      = MAX_SEGS * SI_W;
    localparam int K_W       = $clog2(K + 1);
    localparam int SEG_W     = $clog2(MAX_SEGS + 1);

    typedef enum logic {WAIT_SOF, LOAD} state_t;

    state_t             state;
    logic [N-1:0]       lut_q;
    logic [K-1:0]       ins;
    logic               q;
    logic [N_W-1:0]     n;
    logic [K_W-1:0]     k;
    logic [SEG_W-1:0]   seg;
    logic [SR_W-1:0]    sr;

    logic               accept;
    logic               restart;
    logic [N_W-1:0]     cur_n;
    logic [K_W-1:0]     cur_k;
    logic [SEG_W-1:0]   cur_seg;
    logic [K-1:0]       cur_ins;
    logic [SR_W-1:0]    sr_next;
    logic [N_W-1:0]     idx;
    logic [MASK_BITS-1:0] mask;
    logic               last_idx;
    logic               last_mask;
    logic               idx_bit;
    logic               pass_bit;
    logic               eval_bit;
    logic               q_next;
    logic [N-1:0]       lut_next;

    always_comb begin
        // An accepted si_sof always restarts at segment 0 of LUT 0 with ins
        // cleared; the rest of the datapath then sees that forced position.
        restart = si_valid && si_sof;
        accept  = si_valid && (state == LOAD || si_sof);
        cur_n   = restart ? '0 : n;
        cur_k   = restart ? '0 : k;
        cur_seg = restart ? '0 : seg;
        cur_ins = restart ? '0 : ins;

        sr_next   = (sr << SI_W) | SR_W'(si);
        idx       = sr_next[N_W-1:0];
        mask      = sr_next[MASK_BITS-1:0];
        last_idx  = (cur_k != K_W'(K)) && (cur_seg == SEG_W'(IDX_SEGS - 1));
        last_mask = (cur_k == K_W'(K)) && (cur_seg == SEG_W'(MASK_SEGS - 1));

        if (idx == '1)
            idx_bit = 1'b1;
        else if (idx == N_W'((1 << N_W) - 2))
            idx_bit = q;
        else if (idx < N_W'(N))
            idx_bit = lut_q[idx];
        else
            idx_bit = 1'b0;

        pass_bit = 1'b0;
        for (int unsigned j = 0; j < I; j++)
            if (cur_n == N_W'(j))
                pass_bit = inputs[j];

        eval_bit = (cur_n < N_W'(I)) ? pass_bit : mask[cur_ins];
        q_next   = mask[cur_ins[K-2:0]];

        lut_next        = lut_q;
        lut_next[cur_n] = eval_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_SOF;
            lut_q     <= '0;
            ins       <= '0;
            q         <= 1'b0;
            n         <= '0;
            k         <= '0;
            seg       <= '0;
            sr        <= '0;
            outputs   <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                state <= LOAD;
                sr    <= sr_next;
                if (restart && state == LOAD && (n != '0 || k != '0 || seg != '0))
                    sync_err <= 1'b1;

                n   <= cur_n;
                k   <= cur_k;
                seg <= cur_seg + SEG_W'(1);
                ins <= cur_ins;

                if (last_idx) begin
                    ins <= {cur_ins[K-2:0], idx_bit};
                    k   <= cur_k + K_W'(1);
                    seg <= '0;
                end else if (last_mask) begin
                    lut_q <= lut_next;
                    q     <= q_next;
                    k     <= '0;
                    seg   <= '0;
                    if (cur_n == N_W'(N - 1)) begin
                        n         <= '0;
                        outputs   <= lut_next[N-1 -: O];
                        out_valid <= 1'b1;
                    end else begin
                        n <= cur_n + N_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_s4ga2.sv
// Self-checking bench for s4ga2 with N=6, K=3, I=2, O=2, SI_W=4 (FRAME=5).
// A frame-level reference model evaluates each LUT from its configuration
// when the bench finishes sending that LUT's frame.
module tb_s4ga2;
    localparam int N = 6, K = 3, I = 2, O = 2, SI_W = 4;
    localparam int N_W = 3;
    localparam int FRAME = K + 2;
    localparam int CONST_IDX = 7;
    localparam int Q_IDX = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [SI_W-1:0] si = '0;
    logic            si_valid = 1'b0;
    logic            si_sof = 1'b0;
    logic [I-1:0]    inputs = '0;
    logic [O-1:0]    outputs;
    logic            out_valid;
    logic            sync_err;

    int errors = 0;
    int checks = 0;

    // reference model state and configuration
    bit [N-1:0]   m_lut;
    bit           m_q;
    int           cfg_idx [N][K];
    logic [7:0]   cfg_mask [N];
    logic [O-1:0] exp_out;
    logic         exp_ov;
    logic         exp_err;

    s4ga2 #(.N(N), .K(K), .I(I), .O(O), .SI_W(SI_W)) dut (
        .clk(clk), .rst_n(rst_n), .si(si), .si_valid(si_valid), .si_sof(si_sof),
        .inputs(inputs), .outputs(outputs), .out_valid(out_valid), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(string tag);
        checks++;
        assert ({out_valid, sync_err, outputs} === {exp_ov, exp_err, exp_out}) else begin
            errors++;
            $error("FAIL %s: observed ov/err/out=%b/%b/%b expected %b/%b/%b",
                   tag, out_valid, sync_err, outputs, exp_ov, exp_err, exp_out);
        end
    endtask

    task automatic chk_val(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval(int m);
        int ins = 0;
        bit b;
        for (int kk = 0; kk < K; kk++) begin
            int x = cfg_idx[m][kk];
            if (x == CONST_IDX)  b = 1'b1;
            else if (x == Q_IDX) b = m_q;
            else if (x < N)      b = m_lut[x];
            else                 b = 1'b0;
            ins = ins * 2 + int'(b);
        end
        m_q = cfg_mask[m][ins % 4];
        m_lut[m] = (m < I) ? inputs[m] : cfg_mask[m][ins];
    endtask

    task automatic stall();
        si_valid = 1'b0;
        si = SI_W'($urandom);
        si_sof = 1'($urandom);
        tick();
        si_sof = 1'b0;
        exp_ov = 1'b0;
        chk_state("stall");
    endtask

    // mode 0: no stalls, 1: a stall before every segment but the first of LUT 0,
    // 2: random stalls
    task automatic send_frame(int m, int sof_j, int nsegs, int mode);
        logic [SI_W-1:0] segs [FRAME];
        for (int kk = 0; kk < K; kk++)
            segs[kk] = SI_W'(cfg_idx[m][kk]) | SI_W'(($urandom & 1) << N_W);
        segs[K]     = cfg_mask[m][7:4];
        segs[K + 1] = cfg_mask[m][3:0];
        for (int j = 0; j < nsegs; j++) begin
            if (mode == 1 && !(m == 0 && j == 0)) stall();
            else if (mode == 2 && $urandom_range(0, 2) == 0) stall();
            si_valid = 1'b1;
            si = segs[j];
            si_sof = (j == sof_j);
            tick();
            si_valid = 1'b0;
            si_sof = 1'b0;
            exp_ov = 1'b0;
            if (j == FRAME - 1) begin
                model_eval(m);
                if (m == N - 1) begin
                    exp_ov = 1'b1;
                    exp_out = m_lut[N-1 -: O];
                end
            end
            chk_state("seg");
        end
    endtask

    task automatic send_sweep(bit with_sof, int mode);
        for (int m = 0; m < N; m++) begin
            send_frame(m, (with_sof && m == 0) ? 0 : -1, FRAME, mode);
            // inputs must only matter on the edges that finish LUTs 0..I-1
            if (mode == 2 && m == I - 1) inputs = I'($urandom);
        end
    endtask

    task automatic const_cfg();
        for (int m = 0; m < N; m++) begin
            for (int kk = 0; kk < K; kk++) cfg_idx[m][kk] = CONST_IDX;
            cfg_mask[m] = 8'h80;
        end
    endtask

    task automatic rand_cfg();
        for (int m = 0; m < N; m++) begin
            for (int kk = 0; kk < K; kk++) cfg_idx[m][kk] = int'($urandom_range(0, 7));
            cfg_mask[m] = 8'($urandom);
        end
    endtask

    task automatic model_reset();
        m_lut = '0;
        m_q = 1'b0;
        exp_out = '0;
        exp_ov = 1'b0;
        exp_err = 1'b0;
    endtask

    initial begin
        model_reset();

        // 1: reset, then segments without sof are discarded
        tick();
        tick();
        chk_state("reset");
        rst_n = 1'b1;
        for (int s = 0; s < 100; s++) begin
            si_valid = 1'b1;
            si = SI_W'($urandom);
            si_sof = 1'b0;
            tick();
            chk_state("no_sof");
        end
        si_valid = 1'b0;

        // 2: constant sweep
        const_cfg();
        inputs = I'($urandom);
        send_sweep(1'b1, 0);
        chk_val("const_out", 8'(outputs), 8'h03);
        tick();
        exp_ov = 1'b0;
        chk_state("ov_drop");

        // 3: same sweep with alternating stalls; sof at the start is legal
        send_sweep(1'b1, 1);
        chk_val("stall_out", 8'(outputs), 8'h03);

        // 4: dependency and ordering
        const_cfg();
        cfg_idx[4][0] = 0;
        cfg_idx[5][0] = 4;
        cfg_mask[5] = 8'h08;
        inputs = 2'b01;
        send_sweep(1'b0, 0);
        chk_val("dep_sweep1", 8'(outputs), 8'h01);
        inputs = 2'b00;
        send_sweep(1'b0, 2);
        chk_val("dep_sweep2", 8'(outputs), 8'h02);

        // 5: misplaced sof at LUT 3, segment 2, then a full sweep
        const_cfg();
        for (int m = 0; m < 3; m++) send_frame(m, -1, FRAME, 0);
        send_frame(3, -1, 2, 0);
        exp_err = 1'b1;
        send_sweep(1'b1, 0);
        chk_val("resync_out", 8'(outputs), 8'h03);
        chk_val("resync_err", 8'(sync_err), 8'h01);

        // random configurations, inputs and stalls
        for (int r = 0; r < 6; r++) begin
            rand_cfg();
            inputs = I'($urandom);
            send_sweep(1'($urandom), 2);
        end

        // 6: asynchronous reset during LUT 4
        const_cfg();
        for (int m = 0; m < 4; m++) send_frame(m, -1, FRAME, 0);
        send_frame(4, -1, 2, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_state("async_rst");
        tick();
        rst_n = 1'b1;
        for (int s = 0; s < 7; s++) begin
            si_valid = 1'b1;
            si = SI_W'($urandom);
            si_sof = 1'b0;
            tick();
            chk_state("post_rst");
        end
        si_valid = 1'b0;
        rand_cfg();
        inputs = I'($urandom);
        send_sweep(1'b1, 2);
        const_cfg();
        send_sweep(1'b0, 0);
        chk_val("final_out", 8'(outputs), 8'h03);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
